// File: rtl/patch_feeder_21.sv
// patch_feeder_21: fetches 6x6 activation patches and sequences weight-set windows to a dot channel
`ifndef DATA_LEN
`define DATA_LEN 8
`endif
module patch_feeder_21 #(
    parameter int CS_NUM    = 8,
    parameter int PHASE_NUM = 6,
    parameter int TIMEOUT   = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [9:0]              i_base_addr,
    output logic                    o_mem_re,
    output logic [9:0]              o_mem_addr,
    input  logic [6*`DATA_LEN-1:0]  i_mem_rdata,
    output logic [36*`DATA_LEN-1:0] o_d,
    output logic                    o_dc_load,
    output logic                    o_ws_load,
    output logic [3:0]              o_cs,
    output logic [2:0]              o_phase,
    input  logic                    i_dc_valid,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);
    localparam int RW = 6*`DATA_LEN;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, RUN, GAP, DONE} state_t;

    state_t                    r_state;
    logic [9:0]                r_base;
    logic [9:0]                r_mem_addr;
    logic                      r_mem_re;
    logic [36*`DATA_LEN-1:0]   r_d;
    logic                      r_dc_load;
    logic [3:0]                r_cs;
    logic [2:0]                r_phase;
    logic [2:0]                r_row;
    logic [TW-1:0]             r_tmr;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;

    logic [2:0]                w_phase_nx;
    logic [9:0]                w_fetch_addr;

    // First row address of the next patch; the 10-bit sum wraps modulo 1024
    assign w_phase_nx   = r_phase + 3'd1;
    assign w_fetch_addr = r_base + {7'd0, w_phase_nx} * 10'd6;

    // Job sequencer: fetch six rows, sweep weight sets per patch, separate windows by one gap cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_mem_addr <= '0;
            r_mem_re   <= 1'b0;
            r_d        <= '0;
            r_dc_load  <= 1'b0;
            r_cs       <= '0;
            r_phase    <= '0;
            r_row      <= '0;
            r_tmr      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= FETCH;
                        r_base     <= i_base_addr;
                        r_mem_addr <= i_base_addr;
                        r_mem_re   <= 1'b1;
                        r_row      <= '0;
                        r_cs       <= '0;
                        r_phase    <= '0;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    r_row <= r_row + 3'd1;
                    if (r_row != 3'd0)
                        r_d[32'(r_row - 3'd1) * RW +: RW] <= i_mem_rdata;
                    if (r_row < 3'd5)
                        r_mem_addr <= r_mem_addr + 10'd1;
                    if (r_row == 3'd5)
                        r_mem_re <= 1'b0;
                    if (r_row == 3'd6) begin
                        r_state   <= RUN;
                        r_dc_load <= 1'b1;
                        r_tmr     <= '0;
                    end
                end
                RUN: begin
                    r_tmr <= r_tmr + TW'(1);
                    if (i_dc_valid || r_tmr == TW'(TIMEOUT - 1)) begin
                        r_state   <= GAP;
                        r_dc_load <= 1'b0;
                        if (!i_dc_valid)
                            r_err <= 1'b1;
                    end
                end
                GAP: begin
                    if (r_cs < 4'(CS_NUM - 1)) begin
                        r_cs      <= r_cs + 4'd1;
                        r_state   <= RUN;
                        r_dc_load <= 1'b1;
                        r_tmr     <= '0;
                    end else begin
                        r_cs <= '0;
                        if (r_phase < 3'(PHASE_NUM - 1)) begin
                            r_phase    <= w_phase_nx;
                            r_state    <= FETCH;
                            r_mem_re   <= 1'b1;
                            r_mem_addr <= w_fetch_addr;
                            r_row      <= '0;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_re   = r_mem_re;
    assign o_mem_addr = r_mem_addr;
    assign o_d        = r_d;
    assign o_dc_load  = r_dc_load;
    assign o_ws_load  = r_dc_load;
    assign o_cs       = r_cs;
    assign o_phase    = r_phase;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
endmodule

// File: tb/tb_patch_feeder_21.sv
// tb_patch_feeder_21: directed checks of patch fetch, window sequencing, timeout, start filtering and reset
`timescale 1ns/1ps
`ifndef DATA_LEN
`define DATA_LEN 8
`endif
module tb_patch_feeder_21;
    localparam int DL = `DATA_LEN;
    localparam int RW = 6*DL;
    localparam int PW = 36*DL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       sel    = 1'b0;
    logic       st     = 1'b0;
    logic       dcv_en = 1'b1;
    logic [9:0] base   = '0;

    logic          a_start, a_mem_re, a_dc_load, a_ws_load, a_dc_valid, a_busy, a_done, a_err;
    logic [9:0]    a_mem_addr;
    logic [RW-1:0] a_rdata;
    logic [PW-1:0] a_d;
    logic [3:0]    a_cs;
    logic [2:0]    a_phase;
    int            a_run = 0;

    logic          b_start, b_mem_re, b_dc_load, b_ws_load, b_dc_valid, b_busy, b_done, b_err;
    logic [9:0]    b_mem_addr;
    logic [RW-1:0] b_rdata;
    logic [PW-1:0] b_d;
    logic [3:0]    b_cs;
    logic [2:0]    b_phase;
    int            b_run = 0;

    logic          m_mem_re, m_dc_load, m_ws_load, m_busy, m_done, m_err;
    logic [9:0]    m_mem_addr;
    logic [PW-1:0] m_d;
    logic [3:0]    m_cs;
    logic [2:0]    m_phase;

    patch_feeder_21 u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_base_addr(base),
        .o_mem_re(a_mem_re), .o_mem_addr(a_mem_addr), .i_mem_rdata(a_rdata), .o_d(a_d),
        .o_dc_load(a_dc_load), .o_ws_load(a_ws_load), .o_cs(a_cs), .o_phase(a_phase),
        .i_dc_valid(a_dc_valid), .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
    );

    patch_feeder_21 #(.CS_NUM(1), .PHASE_NUM(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_base_addr(base),
        .o_mem_re(b_mem_re), .o_mem_addr(b_mem_addr), .i_mem_rdata(b_rdata), .o_d(b_d),
        .o_dc_load(b_dc_load), .o_ws_load(b_ws_load), .o_cs(b_cs), .o_phase(b_phase),
        .i_dc_valid(b_dc_valid), .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
    );

    assign a_start    = st && !sel;
    assign b_start    = st && sel;
    assign a_dc_valid = dcv_en && a_dc_load && a_run == 6;
    assign b_dc_valid = dcv_en && b_dc_load && b_run == 6;

    assign m_mem_re   = sel ? b_mem_re   : a_mem_re;
    assign m_mem_addr = sel ? b_mem_addr : a_mem_addr;
    assign m_d        = sel ? b_d        : a_d;
    assign m_dc_load  = sel ? b_dc_load  : a_dc_load;
    assign m_ws_load  = sel ? b_ws_load  : a_ws_load;
    assign m_cs       = sel ? b_cs       : a_cs;
    assign m_phase    = sel ? b_phase    : a_phase;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_done     = sel ? b_done     : a_done;
    assign m_err      = sel ? b_err      : a_err;

    // Memory models (one-cycle read latency, every word = address) and dot-channel latency counters
    always @(posedge clk) begin
        a_run <= a_dc_load ? a_run + 1 : 0;
        b_run <= b_dc_load ? b_run + 1 : 0;
        if (a_mem_re) a_rdata <= {6{DL'(a_mem_addr)}};
        if (b_mem_re) b_rdata <= {6{DL'(b_mem_addr)}};
    end

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] patch(input logic [9:0] b, input int ph);
        logic [PW-1:0] p;
        logic [9:0]    a;
        for (int r = 0; r < 6; r++) begin
            a = 10'(b + ph*6 + r);
            for (int j = 0; j < 6; j++) p[(r*6+j)*DL +: DL] = DL'(a);
        end
        return p;
    endfunction

    task automatic job(input logic [9:0] b, input int cs_n, input int ph_n, input int run_len, input bit poke);
        int n_rd = 0, n_run = 0, len = 0, c = 0, extra = 0;
        bit prev = 0, gap = 0, fin = 0;
        base = b;
        st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        while (!fin && c < 3000) begin
            @(negedge clk);
            c++;
            if (gap) begin
                check("gap_one_cycle", m_dc_load | m_mem_re | m_done, 1'b1);
                gap = 0;
            end
            if (m_mem_re) begin
                check("mem_addr", m_mem_addr, 10'(b + n_rd));
                n_rd++;
            end
            if (m_dc_load && !prev) begin
                check("patch_d", m_d, patch(b, n_run / cs_n));
                check("cs", m_cs, n_run % cs_n);
                check("phase", m_phase, n_run / cs_n);
                check("ws_load_on", m_ws_load, 1'b1);
                n_run++;
                len = 0;
            end
            if (m_dc_load) len++;
            if (!m_dc_load && prev) begin
                check("run_len", len, run_len);
                check("err_window", m_err, run_len == 15);
                check("ws_load_off", m_ws_load, 1'b0);
                gap = 1;
            end
            if (m_done) begin
                check("busy_in_done", m_busy, 1'b1);
                fin = 1;
            end
            prev = m_dc_load;
            st = poke && ((m_mem_re && n_rd == 3) || (m_dc_load && n_run == 2 && len == 3));
        end
        st = 1'b0;
        check("job_finished", fin, 1'b1);
        check("reads", n_rd, 6*ph_n);
        check("windows", n_run, cs_n*ph_n);
        check("final_d", m_d, patch(b, ph_n - 1));
        check("final_cs", m_cs, 0);
        check("final_phase", m_phase, ph_n - 1);
        check("final_err", m_err, run_len == 15);
        repeat (4) begin
            @(negedge clk);
            if (m_done) extra++;
        end
        check("done_once", extra, 0);
        check("idle_after_done", {m_busy, m_mem_re, m_dc_load}, 3'b000);
    endtask

    initial begin
        int n;
        bit prev;
        repeat (2) @(negedge clk);
        check("rst_a_ctl", {a_mem_re, a_dc_load, a_ws_load, a_busy, a_done, a_err}, 6'b0);
        check("rst_a_d", a_d, '0);
        check("rst_b_ctl", {b_mem_re, b_dc_load, b_ws_load, b_busy, b_done, b_err}, 6'b0);
        check("rst_b_addr", {b_mem_addr, b_cs, b_phase}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        job(10'd100, 8, 6, 7, 1'b0);

        dcv_en = 1'b0;
        job(10'd200, 8, 6, 15, 1'b0);
        dcv_en = 1'b1;

        base = 10'd100;
        st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        n = 0;
        prev = 1'b0;
        for (int c = 0; c < 500 && n < 3; c++) begin
            @(negedge clk);
            if (a_dc_load && !prev) n++;
            prev = a_dc_load;
        end
        check("reach_third_run", n, 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_rst_ctl", {a_mem_re, a_dc_load, a_ws_load, a_busy, a_done, a_err}, 6'b0);
        check("midrun_rst_addr", a_mem_addr, 10'd0);
        check("midrun_rst_cs_phase", {a_cs, a_phase}, 7'd0);
        check("midrun_rst_d", a_d, '0);
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_busy | a_mem_re | a_dc_load | a_done) n++;
        end
        check("quiet_after_rst", n, 0);
        check("d_after_rst", a_d, '0);

        job(10'd100, 8, 6, 7, 1'b1);

        sel = 1'b1;
        job(10'd1020, 1, 2, 7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
